// File: rtl/divisor_sequencial_6bits_pkg.sv
// Shared definitions for the sequential 6-bit restoring divider.
// No logic here; consumed by the top and the subtractor.
// No backpressure; constants and types only.
package divisor_sequencial_6bits_pkg;

  localparam int LARGURA = 6;
  localparam logic [LARGURA-1:0] QUOC_DIV_ZERO = 6'h3F;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    CALC   = 2'b01,
    FIM    = 2'b10
  } estado_t;

endpackage

// File: rtl/divisor_sequencial_6bits_subtrator6bits.sv
// 6-bit ripple-borrow subtractor: diferenca = a - b - emprestaInicial.
// Purely combinational, zero cycles.
// No handshake; outputs follow inputs.
module subtrator6bits
  import divisor_sequencial_6bits_pkg::*;
(
  output logic [LARGURA-1:0] diferenca,
  output logic               emprestaFinal,
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  input  logic               emprestaInicial
);

  logic [LARGURA:0] emprestimo;

  assign emprestimo[0] = emprestaInicial;

  for (genvar i = 0; i < LARGURA; i++) begin : gCelula
    assign diferenca[i]    = a[i] ^ b[i] ^ emprestimo[i];
    assign emprestimo[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & emprestimo[i]);
  end

  assign emprestaFinal = emprestimo[LARGURA];

endmodule

// File: rtl/divisor_sequencial_6bits.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// pronto 7 cycles after the accepting edge (1 cycle for divide-by-zero).
// inicio is only sampled in OCIOSO; requests while busy are dropped.
module divisor_sequencial_6bits
  import divisor_sequencial_6bits_pkg::*;
#(
  parameter int N = LARGURA
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inicio,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quociente,
  output logic [N-1:0] resto,
  output logic         ocupado,
  output logic         pronto,
  output logic         erro
);

  estado_t estado, proxEstado;

  logic [N-1:0] regR, regQ, regD;
  logic [2:0]   contador;
  logic [N-1:0] parcial, diferenca, novoR, novoQ;
  logic         emprestaFinal;
  logic         fimIteracao;

  // R never exceeds the processed dividend prefix, so the shifted value fits in N bits
  assign parcial     = {regR[N-2:0], regQ[N-1]};
  assign fimIteracao = (contador == 3'd0);

  subtrator6bits uSubtrator (
    .diferenca      (diferenca),
    .emprestaFinal  (emprestaFinal),
    .a              (parcial),
    .b              (regD),
    .emprestaInicial(1'b0)
  );

  assign novoR = emprestaFinal ? parcial : diferenca;
  assign novoQ = {regQ[N-2:0], ~emprestaFinal};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado <= OCIOSO;
    else          estado <= proxEstado;
  end

  always_comb begin
    proxEstado = estado;
    case (estado)
      OCIOSO:  if (inicio) proxEstado = (divisor != '0) ? CALC : FIM;
      CALC:    if (fimIteracao) proxEstado = FIM;
      FIM:     proxEstado = OCIOSO;
      default: proxEstado = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regR      <= '0;
      regQ      <= '0;
      regD      <= '0;
      contador  <= '0;
      quociente <= '0;
      resto     <= '0;
      erro      <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (inicio) begin
            if (divisor != '0) begin
              regD     <= divisor;
              regQ     <= dividendo;
              regR     <= '0;
              contador <= 3'd5;
              erro     <= 1'b0;
            end else begin
              quociente <= QUOC_DIV_ZERO;
              resto     <= dividendo;
              erro      <= 1'b1;
            end
          end
        end
        CALC: begin
          regR     <= novoR;
          regQ     <= novoQ;
          contador <= contador - 3'd1;
          if (fimIteracao) begin
            quociente <= novoQ;
            resto     <= novoR;
          end
        end
        default: ;
      endcase
    end
  end

  assign ocupado = (estado == CALC);
  assign pronto  = (estado == FIM);

endmodule
